// File: rtl/pong_multi_ball_if.sv
// Pixel/control bundle between the VGA counter, the multi-ball generator and
// the image sender. The producer side (counter and control) is the master;
// the ball generator is the slave.
//
// Handshake: this path has no valid/ready pair. The pixel stream is
// implicitly valid on every clock, and every output follows its inputs by
// exactly one clock. frame_tick and start are single-cycle pulses, pause is a
// level, and wall_hit is a single-cycle pulse.
interface pong_multi_ball_if #(
  parameter int NUM_BALLS = 4
);
  logic [9:0]           hori_cnt;
  logic [9:0]           vert_cnt;
  logic                 frame_tick;
  logic                 start;
  logic                 pause;
  logic [11:0]          rgb_colour;
  logic                 on;
  logic [NUM_BALLS-1:0] wall_hit;
  logic                 running;
  logic [1:0]           dbg_state;

  modport master (
    output hori_cnt, vert_cnt, frame_tick, start, pause,
    input  rgb_colour, on, wall_hit, running, dbg_state
  );

  modport slave (
    input  hori_cnt, vert_cnt, frame_tick, start, pause,
    output rgb_colour, on, wall_hit, running, dbg_state
  );
endinterface

// File: rtl/pong_multi_ball.sv
// N-ball generator for the VGA pong path. Each ball moves on a coarse grid
// (one cell = 2^SCALE_SHIFT pixels square) and reflects off the walls.
// Motion is stepped once every FRAMES_PER_STEP frame ticks while running.
// The pixel colour is composited with the lowest-index ball on top and is
// registered, so it lags hori_cnt/vert_cnt by one clock.
module pong_multi_ball #(
  parameter int                      NUM_BALLS       = 4,
  parameter int                      H_ACTIVE        = 640,
  parameter int                      V_ACTIVE        = 480,
  parameter int                      SCALE_SHIFT     = 4,
  parameter int                      FRAMES_PER_STEP = 4,
  parameter logic [12*NUM_BALLS-1:0] BALL_COLOURS    = 48'hF00_0F0_00F_FF0,
  parameter logic [11:0]             BG_COLOUR       = 12'h000
) (
  input logic              clk,
  input logic              reset,
  pong_multi_ball_if.slave bus
);

  localparam int         GRID_W   = H_ACTIVE >> SCALE_SHIFT;
  localparam int         GRID_H   = V_ACTIVE >> SCALE_SHIFT;
  localparam logic [5:0] X_MAX    = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX    = 6'(GRID_H - 1);
  localparam logic [7:0] DIV_LAST = 8'(FRAMES_PER_STEP - 1);

  // Reject parameter sets where the reset layout would not fit on the grid.
  if (NUM_BALLS < 1 || NUM_BALLS > 8) begin : g_bad_num_balls
    $error("pong_multi_ball: NUM_BALLS must be 1..8");
  end
  if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255) begin : g_bad_frames
    $error("pong_multi_ball: FRAMES_PER_STEP must be 1..255");
  end
  if (NUM_BALLS * 4 + 1 > GRID_W - 1 || NUM_BALLS * 3 + 1 > GRID_H - 1) begin : g_bad_grid
    $error("pong_multi_ball: reset ball layout does not fit the grid");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic                 running_c;
  logic                 step_en;
  logic [7:0]           div;

  logic [5:0]           x      [NUM_BALLS];
  logic [5:0]           y      [NUM_BALLS];
  logic [NUM_BALLS-1:0] dx_neg;
  logic [NUM_BALLS-1:0] dy_neg;

  logic [5:0]           x_nx   [NUM_BALLS];
  logic [5:0]           y_nx   [NUM_BALLS];
  logic [NUM_BALLS-1:0] dx_neg_nx;
  logic [NUM_BALLS-1:0] dy_neg_nx;
  logic [NUM_BALLS-1:0] hit_nx;
  logic [NUM_BALLS-1:0] wall_hit_q;

  logic [9:0]           cell_x;
  logic [9:0]           cell_y;
  logic                 active;
  logic [11:0]          rgb_nx;
  logic                 on_nx;
  logic [11:0]          rgb_q;
  logic                 on_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: start leaves IDLE, pause toggles between RUN and PAUSED.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start)  state_nx = RUN;
      RUN:     if (bus.pause)  state_nx = PAUSED;
      PAUSED:  if (!bus.pause) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // State outputs: running flag and the step strobe on the last divided tick.
  always_comb begin
    running_c = (state == RUN);
    step_en   = running_c && bus.frame_tick && (div == DIV_LAST);
  end

  // Frame divider counts ticks only while running and wraps on the step tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (running_c && bus.frame_tick) begin
      div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
    end
  end

  // Per-ball next position: reflect at either wall, else advance one cell.
  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      x_nx[i]      = dx_neg[i] ? x[i] - 6'd1 : x[i] + 6'd1;
      y_nx[i]      = dy_neg[i] ? y[i] - 6'd1 : y[i] + 6'd1;
      dx_neg_nx[i] = dx_neg[i];
      dy_neg_nx[i] = dy_neg[i];
      hit_nx[i]    = 1'b0;
      if (!dx_neg[i] && x[i] == X_MAX) begin
        x_nx[i]      = X_MAX - 6'd1;
        dx_neg_nx[i] = 1'b1;
        hit_nx[i]    = 1'b1;
      end else if (dx_neg[i] && x[i] == 6'd0) begin
        x_nx[i]      = 6'd1;
        dx_neg_nx[i] = 1'b0;
        hit_nx[i]    = 1'b1;
      end
      if (!dy_neg[i] && y[i] == Y_MAX) begin
        y_nx[i]      = Y_MAX - 6'd1;
        dy_neg_nx[i] = 1'b1;
        hit_nx[i]    = 1'b1;
      end else if (dy_neg[i] && y[i] == 6'd0) begin
        y_nx[i]      = 6'd1;
        dy_neg_nx[i] = 1'b0;
        hit_nx[i]    = 1'b1;
      end
    end
  end

  // Ball state: staggered diagonal layout on reset, updated only on a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        x[i]      <= 6'(4 * i + 1);
        y[i]      <= 6'(3 * i + 1);
        dx_neg[i] <= 1'b0;
        dy_neg[i] <= 1'(i % 2);
      end
    end else if (step_en) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        x[i]      <= x_nx[i];
        y[i]      <= y_nx[i];
        dx_neg[i] <= dx_neg_nx[i];
        dy_neg[i] <= dy_neg_nx[i];
      end
    end
  end

  // Wall-hit pulses: one cycle after a step, one bit per reflecting ball.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wall_hit_q <= '0;
    else       wall_hit_q <= step_en ? hit_nx : '0;
  end

  assign cell_x = bus.hori_cnt >> SCALE_SHIFT;
  assign cell_y = bus.vert_cnt >> SCALE_SHIFT;
  assign active = (bus.hori_cnt < 10'(H_ACTIVE)) && (bus.vert_cnt < 10'(V_ACTIVE));

  // Compositor: walk from the highest index down so the lowest index wins.
  always_comb begin
    rgb_nx = BG_COLOUR;
    on_nx  = 1'b0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (active && cell_x == {4'd0, x[i]} && cell_y == {4'd0, y[i]}) begin
        rgb_nx = BALL_COLOURS[12*i +: 12];
        on_nx  = 1'b1;
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= BG_COLOUR;
      on_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_nx;
      on_q  <= on_nx;
    end
  end

  assign bus.rgb_colour = rgb_q;
  assign bus.on         = on_q;
  assign bus.wall_hit   = wall_hit_q;
  assign bus.running    = running_c;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_pong_multi_ball.sv
// Bench for pong_multi_ball. Directed stimulus with hand-computed pixel
// expectations. Render probes and wall-hit pulses are checked by a monitor
// that pops an expected queue. Wall-hit masks come from a closed-form
// triangle-wave model of each axis. An axis of size G is treated as a
// phase u in 0..2(G-1)-1, and the axis reflects on a step taken from
// u == 0 or u == G-1.
module tb_pong_multi_ball;
  localparam int NB = 4;
  // Ball 0 occupies the low 12 bits: ball0=F00, ball1=0F0, ball2=00F, ball3=FF0.
  localparam logic [47:0] COLS = 48'hFF0_00F_0F0_F00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_multi_ball_if #(.NUM_BALLS(NB)) bus ();

  pong_multi_ball #(
    .NUM_BALLS   (NB),
    .BALL_COLOURS(COLS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Scoreboard state.
  logic [33:0]   exp_q[$];   // {h[9:0], v[9:0], running, on, rgb[11:0]}
  logic [NB-1:0] hit_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  logic          probe_req = 1'b0;
  logic          probe_d   = 1'b0;
  logic [33:0]   e_r;
  logic [NB-1:0] h_r;

  // Model of the control side.
  logic          m_run  = 1'b0;
  int            m_div  = 0;
  int            m_step = 0;

  always @(posedge clk) probe_d <= probe_req;

  // Monitor: compares every registered render result and every wall-hit pulse.
  always @(negedge clk) begin
    if (!reset && probe_d) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL render: output with no expected entry, got rgb=%h on=%b", bus.rgb_colour, bus.on);
      end else begin
        e_r = exp_q.pop_front();
        if ({bus.running, bus.on, bus.rgb_colour} !== e_r[13:0]) begin
          n_bad++;
          $display("FAIL render(%0d,%0d): got run=%b on=%b rgb=%h, want run=%b on=%b rgb=%h",
                   e_r[33:24], e_r[23:14], bus.running, bus.on, bus.rgb_colour,
                   e_r[13], e_r[12], e_r[11:0]);
        end
      end
    end
    if (!reset && bus.wall_hit != '0) begin
      n_vec++;
      if (hit_q.size() == 0) begin
        n_bad++;
        $display("FAIL wall_hit: unexpected pulse got=%b want none (step %0d)", bus.wall_hit, m_step);
      end else begin
        h_r = hit_q.pop_front();
        if (bus.wall_hit !== h_r) begin
          n_bad++;
          $display("FAIL wall_hit: got=%b want=%b (step %0d)", bus.wall_hit, h_r, m_step);
        end
      end
    end
  end

  function automatic int tri_pos(int u, int g);
    return (u <= g - 1) ? u : 2 * (g - 1) - u;
  endfunction

  // Expected wall-hit mask for step number t (1-based).
  function automatic logic [NB-1:0] exp_hits(int t);
    logic [NB-1:0] m;
    int ux, uy, uy0;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      uy0 = (i % 2 == 0) ? 3 * i + 1 : 58 - (3 * i + 1);
      ux  = (4 * i + 1 + t - 1) % 78;
      uy  = (uy0 + t - 1) % 58;
      m[i] = (ux == 0) || (ux == 39) || (uy == 0) || (uy == 29);
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic probe(input int h, input int v, input logic exp_on, input logic [11:0] exp_rgb);
    @(posedge clk); #1;
    bus.hori_cnt = 10'(h);
    bus.vert_cnt = 10'(v);
    probe_req    = 1'b1;
    exp_q.push_back({10'(h), 10'(v), m_run, exp_on, exp_rgb});
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  task automatic tick();
    logic [NB-1:0] m;
    @(posedge clk); #1;
    bus.frame_tick = 1'b1;
    if (m_run) begin
      m_div++;
      if (m_div == 4) begin
        m_div = 0;
        m_step++;
        m = exp_hits(m_step);
        if (m != '0) hit_q.push_back(m);
      end
    end
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic run_to_step(input int s);
    for (int k = 0; k < 20000 && m_step < s; k++) tick();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_run = 1'b1;
  endtask

  task automatic set_pause(input logic p);
    @(posedge clk); #1;
    bus.pause = p;
    repeat (2) @(posedge clk);
    #1;
    m_run = !p;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.hori_cnt   = '0;
    bus.vert_cnt   = '0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb",      16'(bus.rgb_colour), 16'h000);
    check("reset_on",       16'(bus.on),         16'h0);
    check("reset_wall_hit", 16'(bus.wall_hit),   16'h0);
    check("reset_running",  16'(bus.running),    16'h0);
    check("reset_state",    16'(bus.dbg_state),  16'h0);
    reset = 1'b0;

    // Reset layout: ball0 at (1,1), ball1 at (5,4); background and blanking.
    probe(16, 16, 1'b1, 12'hF00);
    probe(80, 64, 1'b1, 12'h0F0);
    probe(0, 0, 1'b0, 12'h000);
    probe(700, 16, 1'b0, 12'h000);

    // No start: ticks must not move anything.
    ticks(10);
    probe(16, 16, 1'b1, 12'hF00);

    // Two steps: ball0 -> (3,3), ball1 -> (7,2).
    pulse_start();
    ticks(8);
    probe(48, 48, 1'b1, 12'hF00);
    probe(112, 32, 1'b1, 12'h0F0);
    probe(16, 16, 1'b0, 12'h000);

    // Step 4: ball1 at (9,0) with dy=-1; step 5 reflects it to (10,1).
    run_to_step(4);
    probe(150, 10, 1'b1, 12'h0F0);
    run_to_step(5);
    probe(160, 16, 1'b1, 12'h0F0);

    // Step 112: balls 0 and 2 share cell (35,3); ball 0 is drawn.
    run_to_step(112);
    probe(560, 48, 1'b1, 12'hF00);
    probe(575, 63, 1'b1, 12'hF00);

    // Paused: ticks are ignored and the balls stay put.
    set_pause(1'b1);
    ticks(20);
    probe(560, 48, 1'b1, 12'hF00);
    set_pause(1'b0);

    // Step 1130: ball0 in the corner (39,29) moving (+1,+1); next step flips both.
    run_to_step(1130);
    probe(624, 464, 1'b1, 12'hF00);
    probe(639, 479, 1'b1, 12'hF00);
    run_to_step(1131);
    probe(608, 448, 1'b1, 12'hF00);
    probe(624, 464, 1'b0, 12'h000);
    probe(700, 464, 1'b0, 12'h000);
    probe(624, 480, 1'b0, 12'h000);

    // Mid-run reset restores the initial layout and IDLE.
    @(posedge clk); #1;
    reset = 1'b1;
    m_run = 1'b0;
    m_div = 0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_running", 16'(bus.running), 16'h0);
    reset = 1'b0;
    probe(16, 16, 1'b1, 12'hF00);

    repeat (4) @(posedge clk);
    #1;
    check("hit_queue_drained",    16'(hit_q.size()), 16'h0);
    check("render_queue_drained", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
